// File: rtl/edge_sched_pkg.sv
// Shared types and helpers for the edge event scheduler: FSM state encoding
// and the channel-index width calculation.
package edge_sched_pkg;

    typedef enum logic {
        IDLE    = 1'b0,
        PRESENT = 1'b1
    } sched_state_t;

    // Width needed to index n channels; never narrower than one bit.
    function automatic int unsigned ch_idx_w(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/edge_event_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: picks the first requester after
// last_grant, wrapping modulo N_CH.
module rr_arbiter
    import edge_sched_pkg::*;
#(
    parameter int unsigned N_CH = 4,
    parameter int unsigned CW   = ch_idx_w(N_CH)
) (
    input  logic [N_CH-1:0] req,
    input  logic [CW-1:0]   last_grant,
    output logic [CW-1:0]   grant,
    output logic            any_valid
);

    int unsigned idx;

    always_comb begin
        grant     = '0;
        any_valid = 1'b0;
        idx       = 0;
        // Offsets 1..N_CH so last_grant itself is searched last.
        for (int unsigned k = 1; k <= N_CH; k++) begin
            idx = (32'(last_grant) + k) % N_CH;
            if (!any_valid && req[idx[CW-1:0]]) begin
                any_valid = 1'b1;
                grant     = idx[CW-1:0];
            end
        end
    end

endmodule

// File: rtl/edge_event_scheduler.sv
// Rising-edge detector per channel feeding a pending/overflow tracker and a
// round-robin scheduled valid/ready event output.
module edge_event_scheduler
    import edge_sched_pkg::*;
#(
    parameter int unsigned N_CH = 4,
    parameter int unsigned CW   = ch_idx_w(N_CH)
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic [N_CH-1:0] level_in,
    input  logic [N_CH-1:0] ch_enable,
    output logic            evt_valid,
    output logic [CW-1:0]   evt_ch,
    input  logic            evt_ready,
    output logic [N_CH-1:0] overflow,
    input  logic            overflow_clr
);

    sched_state_t    state_q, state_d;
    logic [N_CH-1:0] prev_q;
    logic [N_CH-1:0] pending_q, pending_d;
    logic [N_CH-1:0] overflow_q, overflow_d;
    logic [CW-1:0]   evt_ch_q, evt_ch_d;
    logic [CW-1:0]   last_grant_q, last_grant_d;

    logic [N_CH-1:0] rise;
    logic [N_CH-1:0] req;
    logic [N_CH-1:0] grant_vec;
    logic [N_CH-1:0] ovf_set;
    logic [CW-1:0]   win;
    logic            win_valid;
    logic            grant_fire;

    assign rise = level_in & ~prev_q & ch_enable;
    // Disabled channels must not be granted even before their pending bit clears.
    assign req  = pending_q & ch_enable;

    rr_arbiter #(
        .N_CH (N_CH),
        .CW   (CW)
    ) u_arb (
        .req        (req),
        .last_grant (last_grant_q),
        .grant      (win),
        .any_valid  (win_valid)
    );

    always_comb begin
        state_d      = state_q;
        evt_ch_d     = evt_ch_q;
        last_grant_d = last_grant_q;
        grant_fire   = 1'b0;
        case (state_q)
            IDLE: begin
                if (win_valid) begin
                    grant_fire = 1'b1;
                    state_d    = PRESENT;
                end
            end
            PRESENT: begin
                if (evt_ready) begin
                    if (win_valid) grant_fire = 1'b1;
                    else           state_d    = IDLE;
                end
            end
        endcase
        if (grant_fire) begin
            evt_ch_d     = win;
            last_grant_d = win;
        end
    end

    // A rise on the channel being granted re-arms pending instead of overflowing.
    always_comb begin
        grant_vec = '0;
        if (grant_fire) grant_vec[win] = 1'b1;
        pending_d  = ch_enable & (rise | (pending_q & ~grant_vec));
        ovf_set    = rise & pending_q & ~grant_vec;
        overflow_d = (overflow_clr ? '0 : overflow_q) | ovf_set;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            prev_q       <= '0;
            pending_q    <= '0;
            overflow_q   <= '0;
            evt_ch_q     <= '0;
            last_grant_q <= CW'(N_CH - 1);
        end else begin
            state_q      <= state_d;
            prev_q       <= level_in;
            pending_q    <= pending_d;
            overflow_q   <= overflow_d;
            evt_ch_q     <= evt_ch_d;
            last_grant_q <= last_grant_d;
        end
    end

    assign evt_valid = (state_q == PRESENT);
    assign evt_ch    = evt_ch_q;
    assign overflow  = overflow_q;

endmodule

// File: doc/edge_event_scheduler.md
EDGE_EVENT_SCHEDULER -- requirements
Module: edge_event_scheduler

Interface
REQ-001 SHALL have parameter N_CH, default 4, number of level-input channels (2..16).
REQ-002 SHALL have parameter CW, default $clog2(N_CH), width of channel index.
REQ-003 SHALL have port clk, input, 1, sole clock, all state on rising edge.
REQ-004 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port level_in, input, N_CH, per-channel level signals, synchronous to clk.
REQ-006 SHALL have port ch_enable, input, N_CH, per-channel event enable.
REQ-007 SHALL have port evt_valid, output, 1, event presented.
REQ-008 SHALL have port evt_ch, output, CW, index of presented channel.
REQ-009 SHALL have port evt_ready, input, 1, consumer accepts event.
REQ-010 SHALL have port overflow, output, N_CH, sticky per-channel lost-event flags.
REQ-011 SHALL have port overflow_clr, input, 1, clears all overflow bits.

Function
REQ-012 SHALL register level_in into prev[] each cycle; rise[i] = level_in[i] & ~prev[i] & ch_enable[i].
REQ-013 SHALL set pending[i] at the clock edge ending a cycle with rise[i]=1.
REQ-014 SHALL clear pending[i] when ch_enable[i]=0; a rise on a disabled channel is ignored.
REQ-015 SHALL implement FSM IDLE/PRESENT: IDLE->PRESENT when any pending bit set; PRESENT->PRESENT on handshake with other pending; PRESENT->IDLE on handshake with none pending.
REQ-016 SHALL drive evt_valid=1 exactly in PRESENT, registered (no combinational path from inputs).
REQ-017 SHALL on entering PRESENT or on back-to-back handshake load evt_ch with the round-robin winner and clear that pending bit in the same edge.
REQ-018 SHALL select the winner round-robin: search starts at last_grant+1 modulo N_CH; last_grant updates to each granted channel.
REQ-019 SHALL hold evt_valid and evt_ch stable while evt_valid=1 and evt_ready=0.
REQ-020 SHALL have latency: level_in rises in cycle t, evt_valid asserts in cycle t+2 when FSM IDLE.
REQ-021 SHALL sustain one event per cycle with evt_ready held high.
REQ-022 SHALL set overflow[i] when rise[i]=1 while pending[i]=1 and not being cleared that edge; pending[i] stays 1 (events merge).
REQ-023 SHALL treat rise[i] coinciding with grant of channel i as a new pending event, no overflow.
REQ-024 SHALL clear all overflow bits on overflow_clr; a simultaneous set wins for that bit.
REQ-025 SHALL not affect an already-presented event when its ch_enable drops.

Reset
REQ-026 SHALL on reset_n=0 asynchronously clear prev, pending, overflow, evt_valid, evt_ch to 0, FSM to IDLE, last_grant to N_CH-1.
REQ-027 SHALL, since prev resets to 0, produce one event for a channel enabled and high at reset release.

Structure
REQ-028 SHALL place FSM state enum and channel-index width helper in shared package edge_sched_pkg.
REQ-029 SHALL instantiate one sub-module rr_arbiter (request vector, last_grant in; grant index, any-valid out), combinational.

Verification
REQ-030 Reset release with level_in=0, ch_enable=F -> evt_valid=0, overflow=0, evt_ch=0.
REQ-031 Channel 2 rises in cycle 5, evt_ready=1 -> evt_valid=1 evt_ch=2 in cycle 7 only, one pulse.
REQ-032 Channels 0,1,3 rise same cycle, evt_ready=1 -> evt_ch sequence 0,1,3 in consecutive cycles; next 0,1 simultaneous after last_grant=3 -> 0 then 1.
REQ-033 evt_ready=0 with ch1 presented, ch1 falls/rises twice -> evt_ch stays 1, pending[1] set, overflow[1]=1 on second rise; overflow_clr clears it.
REQ-034 ch_enable[3]=0, ch3 rises -> no event; enable after pending set then disable -> pending dropped, no event.
REQ-035 reset_n asserted mid-PRESENT -> evt_valid drops immediately (async), all pending lost, round-robin restarts at channel 0.
